// File: rtl/systolic_buf_ctrl_if.sv
// Array-side bundle: systolic_buf_ctrl is the master, the MAC array the slave.
interface systolic_buf_ctrl_if #(
    parameter int N = 8
);
    logic              arr_start;
    logic              arr_clear;
    logic [7:0]        arr_k_param;
    logic              arr_out_mode;
    logic              arr_calc_done;
    logic              arr_dout_done;
    logic [12:0]       arr_raddr;
    logic              arr_ren_n;
    logic [N*8-1:0]    arr_row_in;
    logic [N*8-1:0]    arr_col_in;
    logic [12:0]       arr_waddr;
    logic              arr_wen_n;
    logic [N*24-1:0]   arr_row_out;
    logic [N*24-1:0]   arr_col_out;

    modport master (
        output arr_start, arr_clear, arr_k_param, arr_out_mode, arr_row_in, arr_col_in,
        input  arr_calc_done, arr_dout_done, arr_raddr, arr_ren_n, arr_waddr, arr_wen_n,
               arr_row_out, arr_col_out
    );

    modport slave (
        input  arr_start, arr_clear, arr_k_param, arr_out_mode, arr_row_in, arr_col_in,
        output arr_calc_done, arr_dout_done, arr_raddr, arr_ren_n, arr_waddr, arr_wen_n,
               arr_row_out, arr_col_out
    );
endinterface

// File: rtl/systolic_buf_ctrl.sv
// Operand buffers, requantizing drain sink and start/clear sequencer for the NxN systolic MAC array.
module systolic_buf_ctrl #(
    parameter int N     = 8,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  host_we,
    input  logic                  host_sel,
    input  logic [AW-1:0]         host_waddr,
    input  logic [N*8-1:0]        host_wdata,
    input  logic [7:0]            k_param,
    input  logic                  out_mode,
    input  logic [4:0]            shift_amt,
    input  logic                  go,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic [$clog2(N)-1:0]  res_raddr,
    output logic [N*8-1:0]        res_rdata,
    systolic_buf_ctrl_if.master   arr
);
    localparam int LW = $clog2(N);

    typedef enum logic [2:0] {IDLE, START, CALC, CLEAR, DRAIN, FIN} state_t;

    state_t           state;
    logic             busy_q, done_q, err_q, start_q, clear_q, mode_q;
    logic [7:0]       k_q;
    logic [4:0]       shift_q;
    logic [N*8-1:0]   row_in_q, col_in_q, res_rdata_q;

    logic [N*8-1:0]   a_mem   [DEPTH];
    logic [N*8-1:0]   b_mem   [DEPTH];
    logic [N*8-1:0]   res_mem [N];

    logic             rd_oob, k_ok, accept, drain_we, err_set, err_clr;
    logic [N*24-1:0]  drain_sel;
    logic [N*8-1:0]   req_word;
    logic             unused_waddr_bits;

    assign rd_oob   = 32'(arr.arr_raddr) >= DEPTH;
    assign k_ok     = (k_param != 8'd0) && (32'(k_param) <= DEPTH);
    assign accept   = (state == IDLE) && go && k_ok;
    assign drain_we = (state == DRAIN) && !arr.arr_wen_n;
    assign err_set  = (host_we && busy_q) || (!arr.arr_ren_n && rd_oob)
                    || ((state == IDLE) && go && !k_ok);
    assign err_clr  = accept;
    assign unused_waddr_bits = ^arr.arr_waddr[12:LW];

    // Round-half-up then arithmetic shift; 25 bits holds v plus the rounding term.
    function automatic logic [7:0] requant(input logic signed [23:0] v, input logic [4:0] sh);
        logic signed [24:0] x;
        logic signed [24:0] r;
        x = {v[23], v};
        if (sh != 5'd0) x = x + (25'sd1 <<< (sh - 5'd1));
        r = x >>> sh;
        if (r > 25'sd127)       return 8'h7f;
        else if (r < -25'sd128) return 8'h80;
        else                    return r[7:0];
    endfunction

    always_comb begin
        drain_sel = mode_q ? arr.arr_col_out : arr.arr_row_out;
        req_word  = '0;
        for (int unsigned i = 0; i < N; i++)
            req_word[8*i +: 8] = requant(drain_sel[24*i +: 24], shift_q);
    end

    always_ff @(posedge clk) begin
        if (!rst && host_we && !busy_q) begin
            if (host_sel) b_mem[host_waddr] <= host_wdata;
            else          a_mem[host_waddr] <= host_wdata;
        end
        if (!rst && drain_we)
            res_mem[arr.arr_waddr[LW-1:0]] <= req_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            clear_q     <= 1'b0;
            mode_q      <= 1'b0;
            k_q         <= '0;
            shift_q     <= '0;
            row_in_q    <= '0;
            col_in_q    <= '0;
            res_rdata_q <= '0;
        end else begin
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            clear_q     <= 1'b0;
            res_rdata_q <= res_mem[res_raddr];
            row_in_q    <= '0;
            col_in_q    <= '0;
            if (!arr.arr_ren_n && !rd_oob) begin
                row_in_q <= a_mem[arr.arr_raddr[AW-1:0]];
                col_in_q <= b_mem[arr.arr_raddr[AW-1:0]];
            end
            err_q <= err_set | (err_q & ~err_clr);
            case (state)
                IDLE: begin
                    if (accept) begin
                        k_q     <= k_param;
                        mode_q  <= out_mode;
                        shift_q <= shift_amt;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= START;
                    end else if (go) begin
                        done_q  <= 1'b1;
                    end
                end
                START: state <= CALC;
                CALC: begin
                    if (arr.arr_calc_done) begin
                        clear_q <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                CLEAR: state <= DRAIN;
                DRAIN: begin
                    if (drain_we && arr.arr_dout_done) begin
                        done_q <= 1'b1;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;
    assign res_rdata        = res_rdata_q;
    assign arr.arr_start    = start_q;
    assign arr.arr_clear    = clear_q;
    assign arr.arr_k_param  = k_q;
    assign arr.arr_out_mode = mode_q;
    assign arr.arr_row_in   = row_in_q;
    assign arr.arr_col_in   = col_in_q;
endmodule

// File: tb/tb_systolic_buf_ctrl.sv
// Directed bench for systolic_buf_ctrl; the bench plays both the host and the MAC array.
module tb_systolic_buf_ctrl;
    localparam int N = 8, DEPTH = 256, AW = 8, LW = 3;

    logic           clk = 1'b0;
    logic           rst, host_we, host_sel, out_mode, go, busy, done, err;
    logic [AW-1:0]  host_waddr;
    logic [N*8-1:0] host_wdata, res_rdata;
    logic [7:0]     k_param;
    logic [4:0]     shift_amt;
    logic [LW-1:0]  res_raddr;

    int errors = 0;
    int checks = 0;

    systolic_buf_ctrl_if #(.N(N)) arr_if ();

    systolic_buf_ctrl #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .host_we(host_we), .host_sel(host_sel),
        .host_waddr(host_waddr), .host_wdata(host_wdata), .k_param(k_param),
        .out_mode(out_mode), .shift_amt(shift_amt), .go(go), .busy(busy),
        .done(done), .err(err), .res_raddr(res_raddr), .res_rdata(res_rdata),
        .arr(arr_if.master)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*8-1:0] bcast8(input logic [7:0] b);
        return {N{b}};
    endfunction

    function automatic logic [N*8-1:0] lane8(input int l, input logic [7:0] b);
        logic [N*8-1:0] w;
        w = '0;
        w[8*l +: 8] = b;
        return w;
    endfunction

    function automatic logic [N*24-1:0] lane24(input logic [N*24-1:0] w, input int l, input int v);
        w[24*l +: 24] = v[23:0];
        return w;
    endfunction

    task automatic host_write(input logic sel, input int addr, input logic [N*8-1:0] data);
        host_we = 1'b1; host_sel = sel; host_waddr = addr[AW-1:0]; host_wdata = data;
        step();
        host_we = 1'b0;
    endtask

    task automatic read_res(input int addr, output logic [N*8-1:0] data);
        res_raddr = addr[LW-1:0];
        step();
        data = res_rdata;
    endtask

    // Leaves the DUT in START, one cycle after go was sampled.
    task automatic start_run(input int k, input logic mode, input int sh);
        k_param = k[7:0]; out_mode = mode; shift_amt = sh[4:0]; go = 1'b1;
        step();
        go = 1'b0;
        checks++;
        if (arr_if.arr_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse: arr_start=%b busy=%b, required 1 1", arr_if.arr_start, busy);
        end
    endtask

    // CALC -> CLEAR -> DRAIN.
    task automatic finish_calc();
        arr_if.arr_calc_done = 1'b1;
        step();
        arr_if.arr_calc_done = 1'b0;
        checks++;
        if (arr_if.arr_clear !== 1'b1) begin
            errors++;
            $display("FAIL clear_pulse: arr_clear=%b, required 1", arr_if.arr_clear);
        end
        step();
    endtask

    task automatic drain_beat(input int waddr, input logic [N*24-1:0] rowv,
                              input logic [N*24-1:0] colv, input logic last);
        arr_if.arr_wen_n = 1'b0; arr_if.arr_waddr = waddr[12:0];
        arr_if.arr_row_out = rowv; arr_if.arr_col_out = colv; arr_if.arr_dout_done = last;
        step();
        arr_if.arr_wen_n = 1'b1; arr_if.arr_dout_done = 1'b0;
    endtask

    task automatic one_beat_run(input int k, input logic mode, input int sh, input int waddr,
                                input logic [N*24-1:0] rowv, input logic [N*24-1:0] colv);
        start_run(k, mode, sh);
        step();
        finish_calc();
        drain_beat(waddr, rowv, colv, 1'b1);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL run_done: done=%b, required 1", done);
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({busy, done, err, arr_if.arr_start, arr_if.arr_clear, arr_if.arr_k_param,
             arr_if.arr_out_mode, arr_if.arr_row_in, arr_if.arr_col_in, res_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%b start=%b clear=%b k=%h mode=%b, required all 0",
                     busy, done, err, arr_if.arr_start, arr_if.arr_clear, arr_if.arr_k_param, arr_if.arr_out_mode);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_identity();
        logic [N*24-1:0] rowv;
        logic [N*8-1:0]  d;
        int              done_cnt;
        for (int r = 0; r < N; r++) begin
            host_write(1'b0, r, lane8(r, 8'h01));
            host_write(1'b1, r, bcast8(8'(r + 1)));
        end
        start_run(8, 1'b0, 0);
        checks++;
        if (arr_if.arr_k_param !== 8'd8 || arr_if.arr_out_mode !== 1'b0) begin
            errors++;
            $display("FAIL latched_ctrl: k=%0d mode=%b, required 8 0", arr_if.arr_k_param, arr_if.arr_out_mode);
        end
        arr_if.arr_calc_done = 1'b1;
        step();
        arr_if.arr_calc_done = 1'b0;
        step();
        checks++;
        if (arr_if.arr_start !== 1'b0 || arr_if.arr_clear !== 1'b0) begin
            errors++;
            $display("FAIL calc_done_in_start: start=%b clear=%b, required 0 0", arr_if.arr_start, arr_if.arr_clear);
        end
        finish_calc();
        done_cnt = 0;
        for (int i = 0; i < N; i++) begin
            rowv = '0;
            for (int j = 0; j < N; j++) rowv = lane24(rowv, j, i + 1);
            drain_beat(i, rowv, '0, i == N - 1);
            if (done === 1'b1) done_cnt++;
        end
        step();
        if (done === 1'b1) done_cnt++;
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL identity_done: done_pulses=%0d busy=%b, required 1 0", done_cnt, busy);
        end
        for (int i = 0; i < N; i++) begin
            read_res(i, d);
            checks++;
            if (d !== bcast8(8'(i + 1))) begin
                errors++;
                $display("FAIL identity_res[%0d]: got %h, required %h", i, d, bcast8(8'(i + 1)));
            end
        end
    endtask

    task automatic test_read_latency();
        host_write(1'b0, 5, bcast8(8'h11));
        host_write(1'b0, DEPTH - 1, bcast8(8'h5a));
        arr_if.arr_ren_n = 1'b0; arr_if.arr_raddr = 13'd5;
        step();
        arr_if.arr_ren_n = 1'b1;
        checks++;
        if (arr_if.arr_row_in !== bcast8(8'h11) || arr_if.arr_col_in !== bcast8(8'h06)) begin
            errors++;
            $display("FAIL read_addr5: row=%h col=%h, required %h %h",
                     arr_if.arr_row_in, arr_if.arr_col_in, bcast8(8'h11), bcast8(8'h06));
        end
        step();
        checks++;
        if (arr_if.arr_row_in !== '0 || arr_if.arr_col_in !== '0) begin
            errors++;
            $display("FAIL read_idle_zero: row=%h col=%h, required 0 0", arr_if.arr_row_in, arr_if.arr_col_in);
        end
        arr_if.arr_ren_n = 1'b0; arr_if.arr_raddr = 13'(DEPTH - 1);
        step();
        arr_if.arr_ren_n = 1'b1;
        checks++;
        if (arr_if.arr_row_in !== bcast8(8'h5a) || err !== 1'b0) begin
            errors++;
            $display("FAIL read_last_addr: row=%h err=%b, required %h 0", arr_if.arr_row_in, err, bcast8(8'h5a));
        end
    endtask

    task automatic test_requant();
        logic [N*24-1:0] v;
        logic [N*8-1:0]  d, e;
        v = lane24(lane24(lane24('0, 0, 300), 2, 7), 3, -1000);
        one_beat_run(1, 1'b0, 2, 0, v, '0);
        read_res(0, d);
        e = lane8(0, 8'd75) | lane8(2, 8'd2) | lane8(3, 8'h80);
        checks++;
        if (d !== e) begin errors++; $display("FAIL requant_sh2: got %h, required %h", d, e); end

        v = lane24(lane24(lane24(lane24(lane24('0, 0, -1000), 1, 200), 2, 127), 3, -128), 4, 128);
        one_beat_run(1, 1'b0, 0, 1, v, '0);
        read_res(1, d);
        e = lane8(0, 8'h80) | lane8(1, 8'h7f) | lane8(2, 8'h7f) | lane8(3, 8'h80) | lane8(4, 8'h7f);
        checks++;
        if (d !== e) begin errors++; $display("FAIL requant_sh0: got %h, required %h", d, e); end

        v = lane24(lane24(lane24(lane24('0, 0, -5), 1, 5), 2, -1), 3, 1);
        one_beat_run(1, 1'b0, 1, 3, v, '0);
        read_res(3, d);
        e = lane8(0, 8'hfe) | lane8(1, 8'h03) | lane8(3, 8'h01);
        checks++;
        if (d !== e) begin errors++; $display("FAIL requant_sh1: got %h, required %h", d, e); end

        v = lane24(lane24(lane24(lane24('0, 0, -8388608), 1, 8388607), 2, 4194304), 3, 4194303);
        one_beat_run(1, 1'b0, 23, 4, v, '0);
        read_res(4, d);
        e = lane8(0, 8'hff) | lane8(1, 8'h01) | lane8(2, 8'h01);
        checks++;
        if (d !== e) begin errors++; $display("FAIL requant_sh23: got %h, required %h", d, e); end
    endtask

    task automatic test_column_mode();
        logic [N*8-1:0] d;
        one_beat_run(4, 1'b1, 0, 2, lane24('0, 3, 99), lane24('0, 3, 40));
        checks++;
        if (arr_if.arr_out_mode !== 1'b1 || arr_if.arr_k_param !== 8'd4) begin
            errors++;
            $display("FAIL col_latched: mode=%b k=%0d, required 1 4", arr_if.arr_out_mode, arr_if.arr_k_param);
        end
        read_res(2, d);
        checks++;
        if (d !== lane8(3, 8'd40)) begin
            errors++;
            $display("FAIL col_res2: got %h, required %h", d, lane8(3, 8'd40));
        end
        arr_if.arr_wen_n = 1'b0; arr_if.arr_waddr = 13'd2;
        arr_if.arr_row_out = lane24('0, 3, 77); arr_if.arr_col_out = lane24('0, 3, 77);
        step();
        arr_if.arr_wen_n = 1'b1;
        read_res(2, d);
        checks++;
        if (d !== lane8(3, 8'd40)) begin
            errors++;
            $display("FAIL wen_outside_drain: got %h, required %h", d, lane8(3, 8'd40));
        end
    endtask

    task automatic test_errors();
        k_param = 8'd0; go = 1'b1;
        step();
        go = 1'b0;
        checks++;
        if (err !== 1'b1 || done !== 1'b1 || arr_if.arr_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_k_go: err=%b done=%b start=%b busy=%b, required 1 1 0 0",
                     err, done, arr_if.arr_start, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL bad_k_after: done=%b err=%b, required 0 1", done, err);
        end
        start_run(2, 1'b0, 0);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL go_clears_err: err=%b, required 0", err); end
        step();
        k_param = 8'd0; go = 1'b1;
        step();
        go = 1'b0;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || arr_if.arr_start !== 1'b0) begin
            errors++;
            $display("FAIL go_while_busy: err=%b busy=%b done=%b start=%b, required 0 1 0 0",
                     err, busy, done, arr_if.arr_start);
        end
        host_write(1'b0, 5, bcast8(8'haa));
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL host_we_busy_err: err=%b, required 1", err); end
        finish_calc();
        drain_beat(6, '0, '0, 1'b1);
        step();
        arr_if.arr_ren_n = 1'b0; arr_if.arr_raddr = 13'd5;
        step();
        arr_if.arr_ren_n = 1'b1;
        checks++;
        if (arr_if.arr_row_in !== bcast8(8'h11)) begin
            errors++;
            $display("FAIL host_we_dropped: A[5]=%h, required %h", arr_if.arr_row_in, bcast8(8'h11));
        end
        start_run(2, 1'b0, 0);
        step();
        arr_if.arr_ren_n = 1'b0; arr_if.arr_raddr = 13'd300;
        step();
        arr_if.arr_ren_n = 1'b1;
        checks++;
        if (arr_if.arr_row_in !== '0 || arr_if.arr_col_in !== '0 || err !== 1'b1) begin
            errors++;
            $display("FAIL raddr_oob: row=%h col=%h err=%b, required 0 0 1",
                     arr_if.arr_row_in, arr_if.arr_col_in, err);
        end
        finish_calc();
        drain_beat(6, '0, '0, 1'b1);
        step();
    endtask

    task automatic test_reset_mid_drain();
        logic [N*8-1:0] d;
        int             done_cnt;
        start_run(8, 1'b1, 3);
        step();
        finish_calc();
        for (int i = 0; i < 3; i++) drain_beat(i, lane24('0, 0, 64), lane24('0, 0, 64), 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({busy, done, arr_if.arr_start, arr_if.arr_clear, arr_if.arr_k_param, arr_if.arr_out_mode} !== '0) begin
            errors++;
            $display("FAIL reset_mid_drain: busy=%b done=%b start=%b clear=%b k=%h mode=%b, required all 0",
                     busy, done, arr_if.arr_start, arr_if.arr_clear, arr_if.arr_k_param, arr_if.arr_out_mode);
        end
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL reset_no_done: pulses=%0d, required 0", done_cnt); end
        one_beat_run(8, 1'b0, 0, 5, lane24('0, 0, 9), '0);
        read_res(5, d);
        checks++;
        if (d !== lane8(0, 8'd9) || busy !== 1'b0) begin
            errors++;
            $display("FAIL rerun_after_reset: res5=%h busy=%b, required %h 0", d, busy, lane8(0, 8'd9));
        end
    endtask

    initial begin
        rst = 1'b1; host_we = 1'b0; host_sel = 1'b0; host_waddr = '0; host_wdata = '0;
        k_param = '0; out_mode = 1'b0; shift_amt = '0; go = 1'b0; res_raddr = '0;
        arr_if.arr_calc_done = 1'b0; arr_if.arr_dout_done = 1'b0; arr_if.arr_raddr = '0;
        arr_if.arr_ren_n = 1'b1; arr_if.arr_waddr = '0; arr_if.arr_wen_n = 1'b1;
        arr_if.arr_row_out = '0; arr_if.arr_col_out = '0;
        test_reset();
        test_identity();
        test_read_latency();
        test_requant();
        test_column_mode();
        test_errors();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
